ex_stage: RTL

- Consumer side of the ID/EX pipeline register.
- Takes the registered decode bundle and forwards operands from MEM/WB.
- Executes ALU ops, plus RV32M multiply/divide on an iterative unit.
- Drives the EX/MEM register, and raises ex_stall so decode and ID/EX hold while a multi-cycle op or a downstream stall is pending.

---
 rtl/ex_stage.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU and EX/MEM register.
// Define RV_MULDIV_EN to build the iterative RV32M multiply/divide unit.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_ex_valid,
  input  logic            RegWrite,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemToReg,
  input  logic            ALUSrc,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic            fwd_mem_we,
  input  logic [4:0]      fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_we,
  input  logic [4:0]      fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  input  logic            mem_stall,
  output logic            ex_stall,
  output logic            ex_mem_valid,
  output logic            ex_mem_RegWrite,
  output logic            ex_mem_MemRead,
  output logic            ex_mem_MemWrite,
  output logic            ex_mem_MemToReg,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [4:0]      ex_mem_rd
);

  logic            a_mem, a_wb, b_mem, b_wb;
  logic [XLEN-1:0] op_a, rs2_fwd, op_b, alu_res;

  assign a_mem = fwd_mem_we && fwd_mem_rd == rs1 && rs1 != 5'd0;
  assign a_wb  = fwd_wb_we && fwd_wb_rd == rs1 && rs1 != 5'd0;
  assign b_mem = fwd_mem_we && fwd_mem_rd == rs2 && rs2 != 5'd0;
  assign b_wb  = fwd_wb_we && fwd_wb_rd == rs2 && rs2 != 5'd0;

  assign op_a = a_mem ? fwd_mem_data :
                a_wb  ? fwd_wb_data  : rs1_data;
  assign rs2_fwd = b_mem ? fwd_mem_data :
                   b_wb  ? fwd_wb_data  : rs2_data;
  assign op_b = ALUSrc ? imm : rs2_fwd;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      5'd0:  alu_res = op_a + op_b;
      5'd1:  alu_res = op_a - op_b;
      5'd2:  alu_res = op_a << op_b[4:0];
      5'd3:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
      5'd4:  alu_res = XLEN'(op_a < op_b);
      5'd5:  alu_res = op_a ^ op_b;
      5'd6:  alu_res = op_a >> op_b[4:0];
      5'd7:  alu_res = XLEN'($signed(op_a) >>> op_b[4:0]);
      5'd8:  alu_res = op_a | op_b;
      5'd9:  alu_res = op_a & op_b;
      5'd10: alu_res = op_b;
      5'd11: alu_res = pc + imm;
      5'd12: alu_res = pc + XLEN'(4);
      default: alu_res = '0;
    endcase
  end

  logic            md_hold, md_done;
  logic [XLEN-1:0] md_res;
  logic [3:0]      md_ctl;
  logic [4:0]      md_rd;

`ifdef RV_MULDIV_EN
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic            spec_q, spec_d;
  logic [3:0]      ctl_q, ctl_d;
  logic [4:0]      rd_q, rd_d;

  logic            md_start, sa, sb, a_neg, b_neg;
  logic            div_zero, div_ovf, ge;
  logic [XLEN-1:0] a_mag, b_mag, rem_sub, quo, rem;
  logic [XLEN:0]   sum, rem_sh;
  logic [2*XLEN-1:0] prod, prod_s;

  assign md_start = id_ex_valid && alu_op[4:3] == 2'b10
                    && state_q == IDLE;
  // Signedness of each operand, from the low three opcode bits.
  assign sa = alu_op[2] ? ~alu_op[0] : (alu_op[1:0] != 2'b11);
  assign sb = alu_op[2] ? ~alu_op[0] : ~alu_op[1];
  assign a_neg = sa & op_a[XLEN-1];
  assign b_neg = sb & op_b[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;
  assign div_zero = alu_op[2] && op_b == '0;
  assign div_ovf  = alu_op[2] && !alu_op[0]
                    && op_a == MIN && op_b == '1;

  assign sum = {1'b0, acc_q}
             + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign rem_sh  = {acc_q, lo_q[XLEN-1]};
  assign ge      = rem_sh >= {1'b0, opb_q};
  assign rem_sub = rem_sh[XLEN-1:0] - opb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    spec_d  = spec_q;
    ctl_d   = ctl_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: if (md_start) begin
        op_d   = alu_op[2:0];
        ctl_d  = {RegWrite, MemRead, MemWrite, MemToReg};
        rd_d   = rd;
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        opb_d  = b_mag;
        acc_d  = '0;
        lo_d   = a_mag;
        cnt_d  = '0;
        spec_d = 1'b0;
        if (div_zero) begin
          spec_d  = 1'b1;
          lo_d    = alu_op[1] ? op_a : '1;
          state_d = DONE;
        end else if (div_ovf) begin
          spec_d  = 1'b1;
          lo_d    = alu_op[1] ? '0 : MIN;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = ge ? rem_sub : rem_sh[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], ge};
        end else begin
          acc_d = sum[XLEN:1];
          lo_d  = {sum[0], lo_q[XLEN-1:1]};
        end
        if (cnt_q == CW'(MD_CYCLES - 1)) state_d = DONE;
      end
      DONE: if (!mem_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      spec_q  <= 1'b0;
      ctl_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
      ctl_q   <= ctl_d;
      rd_q    <= rd_d;
    end
  end

  // Magnitude results get their signs applied only here.
  assign prod   = {acc_q, lo_q};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_q : lo_q;
  assign rem    = rneg_q ? -acc_q : acc_q;

  always_comb begin
    md_res = '0;
    if (spec_q)
      md_res = lo_q;
    else if (op_q[2])
      md_res = op_q[1] ? rem : quo;
    else if (op_q[1:0] == 2'b00)
      md_res = prod_s[XLEN-1:0];
    else
      md_res = prod_s[2*XLEN-1:XLEN];
  end

  assign md_hold = md_start || state_q == BUSY;
  assign md_done = state_q == DONE;
  assign md_ctl  = ctl_q;
  assign md_rd   = rd_q;
`else
  assign md_hold = 1'b0;
  assign md_done = 1'b0;
  assign md_res  = '0;
  assign md_ctl  = '0;
  assign md_rd   = '0;
`endif

  assign ex_stall = mem_stall | md_hold;

  // While the unit iterates, EX/MEM receives bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_valid      <= 1'b0;
      ex_mem_RegWrite   <= 1'b0;
      ex_mem_MemRead    <= 1'b0;
      ex_mem_MemWrite   <= 1'b0;
      ex_mem_MemToReg   <= 1'b0;
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_rd         <= '0;
    end else if (!mem_stall) begin
      if (md_done) begin
        ex_mem_valid      <= 1'b1;
        ex_mem_RegWrite   <= md_ctl[3];
        ex_mem_MemRead    <= md_ctl[2];
        ex_mem_MemWrite   <= md_ctl[1];
        ex_mem_MemToReg   <= md_ctl[0];
        ex_mem_alu_result <= md_res;
        ex_mem_store_data <= rs2_fwd;
        ex_mem_rd         <= md_rd;
      end else if (md_hold) begin
        ex_mem_valid      <= 1'b0;
        ex_mem_RegWrite   <= 1'b0;
        ex_mem_MemRead    <= 1'b0;
        ex_mem_MemWrite   <= 1'b0;
        ex_mem_MemToReg   <= 1'b0;
        ex_mem_alu_result <= '0;
        ex_mem_store_data <= '0;
        ex_mem_rd         <= '0;
      end else begin
        ex_mem_valid      <= id_ex_valid;
        ex_mem_RegWrite   <= id_ex_valid & RegWrite;
        ex_mem_MemRead    <= id_ex_valid & MemRead;
        ex_mem_MemWrite   <= id_ex_valid & MemWrite;
        ex_mem_MemToReg   <= id_ex_valid & MemToReg;
        ex_mem_alu_result <= alu_res;
        ex_mem_store_data <= rs2_fwd;
        ex_mem_rd         <= rd;
      end
    end
  end

endmodule
